// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/compare/shift ops plus iterative MULTU and DIVU
// behind a Start/Busy/Done handshake.
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic [3:0]       ALUControl,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivByZero
);

    localparam int unsigned CntW = SHW + 1;

    localparam logic [3:0] OpAnd   = 4'd0;
    localparam logic [3:0] OpOr    = 4'd1;
    localparam logic [3:0] OpAdd   = 4'd2;
    localparam logic [3:0] OpSub   = 4'd3;
    localparam logic [3:0] OpXor   = 4'd4;
    localparam logic [3:0] OpNor   = 4'd5;
    localparam logic [3:0] OpSlt   = 4'd6;
    localparam logic [3:0] OpSltu  = 4'd7;
    localparam logic [3:0] OpSll   = 4'd8;
    localparam logic [3:0] OpSrl   = 4'd9;
    localparam logic [3:0] OpSra   = 4'd10;
    localparam logic [3:0] OpMultu = 4'd11;
    localparam logic [3:0] OpDivu  = 4'd12;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [CntW-1:0]      r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opb;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     r_hi;
    logic                 r_ovf;
    logic                 r_dbz;
    logic                 r_done;

    logic                 w_go_mul;
    logic                 w_go_div;
    logic                 w_last;
    logic [SHW-1:0]       w_shamt;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH-1:0]     w_sc_result;
    logic [WIDTH-1:0]     w_sc_hi;
    logic                 w_sc_ovf;
    logic                 w_sc_dbz;
    logic [WIDTH:0]       w_mul_hi;
    logic [2*WIDTH-1:0]   w_mul_acc;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_acc;

    assign w_go_mul = (ALUControl == OpMultu);
    assign w_go_div = (ALUControl == OpDivu) && (Operand2 != '0);
    assign w_last   = (r_count == CntW'(1));
    assign w_shamt  = Operand2[SHW-1:0];
    assign w_sum    = Operand1 + Operand2;
    assign w_diff   = Operand1 - Operand2;

    always_comb begin
        w_sc_result = '0;
        w_sc_hi     = '0;
        w_sc_ovf    = 1'b0;
        w_sc_dbz    = 1'b0;
        case (ALUControl)
            OpAnd:  w_sc_result = Operand1 & Operand2;
            OpOr:   w_sc_result = Operand1 | Operand2;
            OpAdd: begin
                w_sc_result = w_sum;
                w_sc_ovf    = (Operand1[WIDTH-1] == Operand2[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != Operand1[WIDTH-1]);
            end
            OpSub: begin
                w_sc_result = w_diff;
                w_sc_ovf    = (Operand1[WIDTH-1] != Operand2[WIDTH-1]) &&
                              (w_diff[WIDTH-1] != Operand1[WIDTH-1]);
            end
            OpXor:  w_sc_result = Operand1 ^ Operand2;
            OpNor:  w_sc_result = ~(Operand1 | Operand2);
            OpSlt:  w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(Operand1) < $signed(Operand2))};
            OpSltu: w_sc_result = {{(WIDTH-1){1'b0}}, (Operand1 < Operand2)};
            OpSll:  w_sc_result = Operand1 << w_shamt;
            OpSrl:  w_sc_result = Operand1 >> w_shamt;
            OpSra:  w_sc_result = $unsigned($signed(Operand1) >>> w_shamt);
            OpDivu: begin
                // Only reaches the result registers when the divisor is zero.
                w_sc_result = '1;
                w_sc_hi     = Operand1;
                w_sc_dbz    = 1'b1;
            end
            default: ;
        endcase
    end

    // Shift-add step: acc = {hi, multiplier}; add multiplicand into hi, then shift right.
    assign w_mul_hi  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_acc = {w_mul_hi, r_acc[WIDTH-1:1]};

    // Restoring step: acc = {remainder, dividend/quotient}.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_acc   = w_div_diff[WIDTH] ?
                         {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0} :
                         {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (Start && w_go_mul) begin
                    w_state_next = StMul;
                end else if (Start && w_go_div) begin
                    w_state_next = StDiv;
                end
            end
            StMul, StDiv: begin
                if (w_last) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        Busy      = (r_state != StIdle);
        Done      = r_done;
        ALUResult = r_result;
        ResultHi  = r_hi;
        Zero      = (r_result == '0);
        Overflow  = r_ovf;
        DivByZero = r_dbz;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_ovf    <= 1'b0;
            r_dbz    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (Start && (w_go_mul || w_go_div)) begin
                        r_acc   <= {{WIDTH{1'b0}}, Operand1};
                        r_opb   <= Operand2;
                        r_count <= CntW'(WIDTH);
                    end else if (Start) begin
                        r_result <= w_sc_result;
                        r_hi     <= w_sc_hi;
                        r_ovf    <= w_sc_ovf;
                        r_dbz    <= w_sc_dbz;
                        r_done   <= 1'b1;
                    end
                end
                StMul: begin
                    r_acc   <= w_mul_acc;
                    r_count <= r_count - CntW'(1);
                    if (w_last) begin
                        r_result <= w_mul_acc[WIDTH-1:0];
                        r_hi     <= w_mul_acc[2*WIDTH-1:WIDTH];
                        r_ovf    <= 1'b0;
                        r_dbz    <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                StDiv: begin
                    r_acc   <= w_div_acc;
                    r_count <= r_count - CntW'(1);
                    if (w_last) begin
                        r_result <= w_div_acc[WIDTH-1:0];
                        r_hi     <= w_div_acc[2*WIDTH-1:WIDTH];
                        r_ovf    <= 1'b0;
                        r_dbz    <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: a WIDTH=32 and a WIDTH=8 instance, each checked every cycle against an
// arithmetic reference model, plus directed cases with literal expectations.
module tb_seq_alu;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        ov;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        t_start [2];
    logic [3:0]  t_op    [2];
    logic [31:0] t_a     [2];
    logic [31:0] t_b     [2];

    logic        o_busy [2];
    logic        o_done [2];
    logic        o_zero [2];
    logic        o_ov   [2];
    logic        o_dz   [2];
    logic [31:0] o_res  [2];
    logic [31:0] o_hi   [2];
    logic [7:0]  res8;
    logic [7:0]  hi8;

    int checks = 0;
    int failures = 0;
    bit checking = 1'b0;

    exp_t m_out  [2];
    exp_t m_pend [2];
    logic m_done [2];
    int   m_left [2];

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) u_dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .Start      (t_start[0]),
        .Operand1   (t_a[0]),
        .Operand2   (t_b[0]),
        .ALUControl (t_op[0]),
        .Busy       (o_busy[0]),
        .Done       (o_done[0]),
        .ALUResult  (o_res[0]),
        .ResultHi   (o_hi[0]),
        .Zero       (o_zero[0]),
        .Overflow   (o_ov[0]),
        .DivByZero  (o_dz[0])
    );

    seq_alu #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .Start      (t_start[1]),
        .Operand1   (t_a[1][7:0]),
        .Operand2   (t_b[1][7:0]),
        .ALUControl (t_op[1]),
        .Busy       (o_busy[1]),
        .Done       (o_done[1]),
        .ALUResult  (res8),
        .ResultHi   (hi8),
        .Zero       (o_zero[1]),
        .Overflow   (o_ov[1]),
        .DivByZero  (o_dz[1])
    );

    assign o_res[1] = {24'd0, res8};
    assign o_hi[1]  = {24'd0, hi8};

    function automatic int wof(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    // Reference: true integer arithmetic on w-bit values, reduced modulo 2^w.
    function automatic exp_t model_op(input int w, input logic [3:0] op,
                                      input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint unsigned mask, ua, ub, p;
        longint sa, sb, full, maxs, mins;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        ua   = 64'(a) & mask;
        ub   = 64'(b) & mask;
        sa   = ((ua >> (w - 1)) != 0) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb   = ((ub >> (w - 1)) != 0) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        maxs = longint'(64'd1 << (w - 1)) - 1;
        mins = -longint'(64'd1 << (w - 1));
        sh   = int'(ub % 64'(w));
        e    = '0;
        p    = 0;
        case (op)
            4'd0:  p = ua & ub;
            4'd1:  p = ua | ub;
            4'd2: begin
                p    = ua + ub;
                full = sa + sb;
                e.ov = (full > maxs) || (full < mins);
            end
            4'd3: begin
                p    = ua - ub;
                full = sa - sb;
                e.ov = (full > maxs) || (full < mins);
            end
            4'd4:  p = ua ^ ub;
            4'd5:  p = ~(ua | ub);
            4'd6:  p = (sa < sb) ? 1 : 0;
            4'd7:  p = (ua < ub) ? 1 : 0;
            4'd8:  p = ua << sh;
            4'd9:  p = ua >> sh;
            4'd10: p = longint'(sa >>> sh);
            4'd11: begin
                p    = ua * ub;
                e.hi = 32'((p >> w) & mask);
            end
            4'd12: begin
                if (ub == 0) begin
                    p    = mask;
                    e.hi = 32'(ua);
                    e.dz = 1'b1;
                end else begin
                    p    = ua / ub;
                    e.hi = 32'(ua % ub);
                end
            end
            default: p = 0;
        endcase
        e.res = 32'(p & mask);
        return e;
    endfunction

    function automatic bit is_long(input int w, input logic [3:0] op, input logic [31:0] b);
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        return (op == 4'd11) || ((op == 4'd12) && ((64'(b) & mask) != 0));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_out[d]  <= '0;
                m_pend[d] <= '0;
                m_done[d] <= 1'b0;
                m_left[d] <= 0;
            end else begin
                m_done[d] <= 1'b0;
                if (m_left[d] > 0) begin
                    m_left[d] <= m_left[d] - 1;
                    if (m_left[d] == 1) begin
                        m_out[d]  <= m_pend[d];
                        m_done[d] <= 1'b1;
                    end
                end else if (t_start[d]) begin
                    if (is_long(wof(d), t_op[d], t_b[d])) begin
                        m_pend[d] <= model_op(wof(d), t_op[d], t_a[d], t_b[d]);
                        m_left[d] <= wof(d);
                    end else begin
                        m_out[d]  <= model_op(wof(d), t_op[d], t_a[d], t_b[d]);
                        m_done[d] <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s w%0d @%0t: got %h expected %h", name, wof(d), $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < 2; d++) begin
                chk("model.busy", d, 32'(o_busy[d]), 32'(m_left[d] > 0));
                chk("model.done", d, 32'(o_done[d]), 32'(m_done[d]));
                chk("model.res", d, o_res[d], m_out[d].res);
                chk("model.hi", d, o_hi[d], m_out[d].hi);
                chk("model.zero", d, 32'(o_zero[d]), 32'(m_out[d].res == 32'd0));
                chk("model.ovf", d, 32'(o_ov[d]), 32'(m_out[d].ov));
                chk("model.dbz", d, 32'(o_dz[d]), 32'(m_out[d].dz));
            end
        end
    end

    // Called at a falling edge; Start is seen by exactly one rising edge.
    task automatic issue(input int d, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        t_start[d] = 1'b1;
        t_op[d]    = op;
        t_a[d]     = a;
        t_b[d]     = b;
        @(negedge clk);
        t_start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, output int lat);
        lat = 0;
        while (!o_done[d] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic expect_out(input string name, input int d, input int lat, input int exp_lat,
                              input logic [31:0] res, input logic [31:0] hi, input logic z,
                              input logic ov, input logic dz);
        chk({name, ".lat"}, d, 32'(lat), 32'(exp_lat));
        chk({name, ".done"}, d, 32'(o_done[d]), 32'd1);
        chk({name, ".busy"}, d, 32'(o_busy[d]), 32'd0);
        chk({name, ".res"}, d, o_res[d], res);
        chk({name, ".hi"}, d, o_hi[d], hi);
        chk({name, ".zero"}, d, 32'(o_zero[d]), 32'(z));
        chk({name, ".ovf"}, d, 32'(o_ov[d]), 32'(ov));
        chk({name, ".dbz"}, d, 32'(o_dz[d]), 32'(dz));
    endtask

    task automatic run(input string name, input int d, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                       input logic [31:0] res, input logic [31:0] hi, input logic z,
                       input logic ov, input logic dz);
        int lat;
        issue(d, op, a, b);
        wait_done(d, lat);
        expect_out(name, d, lat, exp_lat, res, hi, z, ov, dz);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_007F;
            5: return 32'h0000_0080;
            6: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        bit saw_done;
        for (int d = 0; d < 2; d++) begin
            t_start[d] = 1'b0;
            t_op[d]    = 4'd0;
            t_a[d]     = 32'd0;
            t_b[d]     = 32'd0;
        end
        repeat (2) @(negedge clk);
        chk("reset.res", 0, o_res[0], 32'd0);
        chk("reset.zero", 0, 32'(o_zero[0]), 32'd1);
        chk("reset.busy", 0, 32'(o_busy[0]), 32'd0);
        chk("reset.done", 0, 32'(o_done[0]), 32'd0);
        rst_n    = 1'b1;
        checking = 1'b1;
        @(negedge clk);

        run("add_ovf", 0, 4'd2, 32'h7FFF_FFFF, 32'd1, 0, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0);
        run("sub_zero", 0, 4'd3, 32'd5, 32'd5, 0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        run("and_zero", 0, 4'd0, 32'hF0F0, 32'h0F0F, 0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        run("slt", 0, 4'd6, 32'hFFFF_FFFF, 32'd1, 0, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        run("sltu", 0, 4'd7, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        run("sra", 0, 4'd10, 32'h8000_0000, 32'd4, 0, 32'hF800_0000, 32'd0, 1'b0, 1'b0, 1'b0);
        run("sll33", 0, 4'd8, 32'd1, 32'd33, 0, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0);
        run("sub_ovf", 0, 4'd3, 32'h8000_0000, 32'd1, 0, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1,
            1'b0);
        run("reserved", 0, 4'd13, 32'd5, 32'd6, 0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // MULTU with a Start pulsed while busy; the ADD must be dropped.
        issue(0, 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        chk("mul_mid.busy", 0, 32'(o_busy[0]), 32'd1);
        issue(0, 4'd2, 32'd1, 32'd2);
        wait_done(0, lat);
        expect_out("mul_ign", 0, lat + 5, 32, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        run("mul_small", 0, 4'd11, 32'd3, 32'd5, 32, 32'd15, 32'd0, 1'b0, 1'b0, 1'b0);
        run("divu", 0, 4'd12, 32'd100, 32'd7, 32, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
        run("div0", 0, 4'd12, 32'd9, 32'd0, 0, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0, 1'b1);

        // ADD issued in the Done cycle of a DIVU.
        issue(0, 4'd12, 32'd100, 32'd7);
        wait_done(0, lat);
        chk("b2b.div_res", 0, o_res[0], 32'd14);
        issue(0, 4'd2, 32'd3, 32'd4);
        expect_out("b2b.add", 0, 0, 0, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);

        // Reset in cycle 10 of a MULTU.
        issue(0, 4'd11, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.busy", 0, 32'(o_busy[0]), 32'd0);
        chk("abort.done", 0, 32'(o_done[0]), 32'd0);
        chk("abort.res", 0, o_res[0], 32'd0);
        chk("abort.hi", 0, o_hi[0], 32'd0);
        chk("abort.zero", 0, 32'(o_zero[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (o_done[0]) saw_done = 1'b1;
        end
        chk("abort.no_done", 0, 32'(saw_done), 32'd0);

        run("add_ovf8", 1, 4'd2, 32'h7F, 32'd1, 0, 32'h80, 32'd0, 1'b0, 1'b1, 1'b0);
        run("sra8", 1, 4'd10, 32'h80, 32'd4, 0, 32'hF8, 32'd0, 1'b0, 1'b0, 1'b0);
        run("sll9_8", 1, 4'd8, 32'd1, 32'd9, 0, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0);
        run("mul8", 1, 4'd11, 32'hFF, 32'hFF, 8, 32'h01, 32'hFE, 1'b0, 1'b0, 1'b0);
        run("divu8", 1, 4'd12, 32'd100, 32'd7, 8, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
        run("div0_8", 1, 4'd12, 32'd9, 32'd0, 0, 32'hFF, 32'd9, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            for (int d = 0; d < 2; d++) begin
                t_start[d] = ($urandom_range(0, 3) == 0);
                t_op[d]    = 4'($urandom_range(0, 15));
                t_a[d]     = rand_operand();
                t_b[d]     = rand_operand();
            end
            @(negedge clk);
        end
        t_start[0] = 1'b0;
        t_start[1] = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
